// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if
//   Handshake bundle for the buffered N:1 selector.
//   Ports (signals):
//     in_data   N*WIDTH  channel k at [k*WIDTH +: WIDTH]
//     in_valid  N        channel k offers a word
//     in_ready  N        channel k's word is taken this cycle (one-hot or zero)
//     sel       SELW     channel select (fixed mode only)
//     out_data  WIDTH    registered selected word
//     out_valid 1        out_data holds an unconsumed word
//     out_ready 1        consumer takes out_data this cycle
//     grant     SELW     channel that supplied the current out_data
//   Modports: master = sources/consumer side, slave = the selector.
interface mux_arb_n_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    grant;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, grant
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, grant
    );
endinterface

// File: rtl/mux_arb_n.sv
// mux_arb_n
//   One-stage buffered N:1 selector with valid/ready on every channel.
//   MODE=0 selects the channel given by sel (sel >= N selects nothing);
//   MODE=1 arbitrates round-robin starting from the channel after the
//   last grant.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  mux_arb_n_if slave modport (all handshake and data signals)
module mux_arb_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0
) (
    input logic         clk,
    input logic         rst,
    mux_arb_n_if.slave  bus
);
    localparam int SELW = $clog2(N);

    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SELW-1:0]  grant_q;
    logic [SELW-1:0]  ptr_q;
    logic [SELW-1:0]  ptr_d;

    logic             load_en;
    logic             found;
    logic [SELW-1:0]  cand;
    logic [WIDTH-1:0] cand_data;
    logic             xfer;
    logic [N-1:0]     in_ready_c;
    int               idx;

    always_comb begin
        load_en = !out_valid_q || bus.out_ready;
        found   = 1'b0;
        cand    = '0;
        idx     = 0;
        if (MODE == 0) begin
            // A sel value with no matching channel leaves found low.
            for (int k = 0; k < N; k++) begin
                if (int'(bus.sel) == k) begin
                    found = bus.in_valid[k];
                    cand  = SELW'(k);
                end
            end
        end else begin
            // Search ptr, ptr+1, ... wrapping at N; first valid wins.
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N) idx = idx - N;
                if (!found && bus.in_valid[idx]) begin
                    found = 1'b1;
                    cand  = SELW'(idx);
                end
            end
        end

        // Reset forces in_ready low so no source believes its word was taken.
        xfer = found && load_en && !rst;

        in_ready_c = '0;
        cand_data  = '0;
        for (int k = 0; k < N; k++) begin
            in_ready_c[k] = xfer && (cand == SELW'(k));
            if (cand == SELW'(k)) cand_data = bus.in_data[k*WIDTH +: WIDTH];
        end

        ptr_d = (int'(cand) == N - 1) ? '0 : cand + SELW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            ptr_q       <= '0;
        end else if (xfer) begin
            out_data_q  <= cand_data;
            grant_q     <= cand;
            out_valid_q <= 1'b1;
            if (MODE == 1) ptr_q <= ptr_d;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.grant     = grant_q;
endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance 0: MODE=0 N=2, instance 1: MODE=1 N=4, instance 2: MODE=0 N=3
    int n_of    [NI] = '{2, 4, 3};
    int mode_of [NI] = '{0, 1, 0};

    logic [31:0] d_drv [NI][4];
    logic [3:0]  v_drv [NI];
    logic [1:0]  s_drv [NI];
    logic        r_drv [NI];

    logic [31:0] od_mon [NI];
    logic        ov_mon [NI];
    logic [1:0]  g_mon  [NI];
    logic [3:0]  ir_mon [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int NG = (g == 0) ? 2 : ((g == 1) ? 4 : 3);
        localparam int MG = (g == 1) ? 1 : 0;
        localparam int SW = $clog2(NG);

        mux_arb_n_if #(.WIDTH(32), .N(NG)) bus ();
        mux_arb_n #(.WIDTH(32), .N(NG), .MODE(MG)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        for (genvar k = 0; k < NG; k++) begin : g_ch
            assign bus.in_data[k*32 +: 32] = d_drv[g][k];
        end
        assign bus.in_valid  = v_drv[g][NG-1:0];
        assign bus.sel       = s_drv[g][SW-1:0];
        assign bus.out_ready = r_drv[g];
        assign od_mon[g]     = bus.out_data;
        assign ov_mon[g]     = bus.out_valid;
        assign g_mon[g]      = 2'(bus.grant);
        assign ir_mon[g]     = 4'(bus.in_ready);
    end

    // reference model: contents of the output stage plus the arbitration pointer
    bit          m_v [NI];
    logic [31:0] m_d [NI];
    int          m_g [NI];
    int          m_p [NI];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            m_v[g] = 1'b0;
            m_d[g] = '0;
            m_g[g] = 0;
            m_p[g] = 0;
        end
    endtask

    // Which channel the rules allow to transfer now (-1 = none), ignoring load_en.
    function automatic int pick(input int g);
        if (mode_of[g] == 0) begin
            int s;
            s = int'(s_drv[g]);
            if (s < n_of[g] && v_drv[g][s]) return s;
            return -1;
        end
        for (int i = 0; i < n_of[g]; i++) begin
            int k;
            k = (m_p[g] + i) % n_of[g];
            if (v_drv[g][k]) return k;
        end
        return -1;
    endfunction

    // One clock: check in_ready against the model, advance, check outputs.
    task automatic step();
        int c  [NI];
        bit dr [NI];
        #1;
        for (int g = 0; g < NI; g++) begin
            c[g]  = (!m_v[g] || r_drv[g]) ? pick(g) : -1;
            dr[g] = m_v[g] && r_drv[g];
            chk("in_ready", g, 32'(ir_mon[g]), (c[g] >= 0) ? (32'd1 << c[g]) : 32'd0);
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            if (c[g] >= 0) begin
                m_d[g] = d_drv[g][c[g]];
                m_g[g] = c[g];
                m_v[g] = 1'b1;
                if (mode_of[g] == 1) m_p[g] = (c[g] + 1) % n_of[g];
            end else if (dr[g]) begin
                m_v[g] = 1'b0;
            end
            chk("out_valid", g, 32'(ov_mon[g]), 32'(m_v[g]));
            chk("out_data",  g, od_mon[g], m_d[g]);
            chk("grant",     g, 32'(g_mon[g]), 32'(m_g[g]));
        end
    endtask

    task automatic idle(input int g);
        v_drv[g] = '0;
        r_drv[g] = 1'b1;
        s_drv[g] = '0;
    endtask

    int exp_rr  [5] = '{0, 1, 2, 3, 0};
    int exp_gap [3] = '{3, 1, 3};

    initial begin
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            idle(g);
            for (int k = 0; k < 4; k++) d_drv[g][k] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("rst_out_valid", g, 32'(ov_mon[g]), 32'd0);
            chk("rst_out_data",  g, od_mon[g], 32'd0);
            chk("rst_grant",     g, 32'(g_mon[g]), 32'd0);
            chk("rst_in_ready",  g, 32'(ir_mon[g]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // fixed select, N=2
        d_drv[0][0] = 32'h0000abcd;
        d_drv[0][1] = 32'habcd0000;
        v_drv[0] = 4'b0011;
        s_drv[0] = 2'd0;
        #1 chk("t1_ready_sel0", 0, 32'(ir_mon[0]), 32'h1);
        step();
        chk("t1_data0",  0, od_mon[0], 32'h0000abcd);
        chk("t1_grant0", 0, 32'(g_mon[0]), 32'd0);
        s_drv[0] = 2'd1;
        #1 chk("t1_ready_sel1", 0, 32'(ir_mon[0]), 32'h2);
        step();
        chk("t1_data1",  0, od_mon[0], 32'habcd0000);
        chk("t1_grant1", 0, 32'(g_mon[0]), 32'd1);

        // backpressure
        s_drv[0] = 2'd0;
        step();
        chk("bp_load", 0, od_mon[0], 32'h0000abcd);
        r_drv[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) d_drv[0][0] = 32'h12345678;
            #1 chk("bp_ready", 0, 32'(ir_mon[0]), 32'h0);
            step();
            chk("bp_hold_data",  0, od_mon[0], 32'h0000abcd);
            chk("bp_hold_valid", 0, 32'(ov_mon[0]), 32'd1);
        end
        r_drv[0] = 1'b1;
        #1 chk("bp_release_ready", 0, 32'(ir_mon[0]), 32'h1);
        step();
        chk("bp_new_data",  0, od_mon[0], 32'h12345678);
        chk("bp_new_valid", 0, 32'(ov_mon[0]), 32'd1);
        v_drv[0] = '0;
        step();
        chk("bp_drain", 0, 32'(ov_mon[0]), 32'd0);

        // round-robin, all valid
        for (int k = 0; k < 4; k++) d_drv[1][k] = 32'h10 + 32'(k);
        v_drv[1] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_grant", 1, 32'(g_mon[1]), 32'(exp_rr[i]));
            chk("rr_data",  1, od_mon[1], 32'h10 + 32'(exp_rr[i]));
        end
        step();
        chk("rr_grant_to_ptr2", 1, 32'(g_mon[1]), 32'd1);

        // round-robin with gaps, ptr = 2
        v_drv[1] = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1 chk("gap_no_ready_0_2", 1, 32'(ir_mon[1] & 4'b0101), 32'd0);
            step();
            chk("gap_grant", 1, 32'(g_mon[1]), 32'(exp_gap[i]));
        end
        idle(1);

        // invalid select on N=3
        for (int k = 0; k < 4; k++) d_drv[2][k] = 32'h300 + 32'(k);
        v_drv[2] = 4'b0111;
        s_drv[2] = 2'd1;
        step();
        chk("inv_load", 2, od_mon[2], 32'h301);
        s_drv[2] = 2'd3;
        #1 chk("inv_ready", 2, 32'(ir_mon[2]), 32'd0);
        step();
        chk("inv_drain", 2, 32'(ov_mon[2]), 32'd0);
        step();
        chk("inv_stay_empty", 2, 32'(ov_mon[2]), 32'd0);
        idle(2);

        // reset mid-stall; ptr is 0 here so the load grants 0 and leaves ptr=1
        v_drv[1] = 4'b1111;
        step();
        chk("rs_load_grant", 1, 32'(g_mon[1]), 32'd0);
        r_drv[1] = 1'b0;
        step();
        chk("rs_stalled", 1, 32'(ov_mon[1]), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("rs_valid", 1, 32'(ov_mon[1]), 32'd0);
        chk("rs_data",  1, od_mon[1], 32'd0);
        chk("rs_grant", 1, 32'(g_mon[1]), 32'd0);
        chk("rs_ready", 1, 32'(ir_mon[1]), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        r_drv[1] = 1'b1;
        step();
        chk("rs_first_grant", 1, 32'(g_mon[1]), 32'd0);
        chk("rs_first_data",  1, od_mon[1], 32'h10);

        // randomized traffic on all three instances
        for (int it = 0; it < 400; it++) begin
            for (int g = 0; g < NI; g++) begin
                for (int k = 0; k < 4; k++) d_drv[g][k] = $urandom;
                v_drv[g] = 4'($urandom);
                s_drv[g] = 2'($urandom_range(0, (g == 0) ? 1 : 3));
                r_drv[g] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
